tag_event_serializer: RTL and testbench
=======================================

Name: tag_event_serializer

Overview:
- Sits directly downstream of the frontend time-tag generator and the single-event packer.
- Arbitrates between the 128-bit time-tag stream and the 128-bit single-event stream.
- Emits each accepted packet as four 32-bit words, MSB word first, on a valid/ready uplink.
- Drives the generator's stall input, so a time tag is never offered while an event packet is mid-transfer.

Parameters:
- OUT_W, 32: output word width. Fixed at 32, which gives 4 words per 128-bit packet.
- ERR_W, 16: width of the saturating framing-error counter.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- tt_valid  in  1  time tag available.
- tt_ready  out  1  time tag accepted this cycle.
- tt  in  128  time-tag packet.
- tt_stall  out  1  to the generator's stall input; masks its valid.
- ev_valid  in  1  single event available.
- ev_ready  out  1  event accepted this cycle.
- ev  in  128  event packet.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  32  output word.
- out_last  out  1  marks word 3 of a packet.
- out_is_tt  out  1  current packet came from the time-tag source.
- err_count  out  ERR_W  framing-error count.

Behaviour:
- Reset (asynchronous assert; deassert synchronised by the integrator) clears all outputs and state:
  - state=IDLE, word index=0, shift register=0, src=0.
  - out_valid=0, out_last=0, out_is_tt=0, tt_ready=0, ev_ready=0, tt_stall=0, err_count=0.
- States: IDLE and SEND.
- IDLE:
  - tt_ready = tt_valid.
  - ev_ready = ev_valid & ~tt_valid. Time tag has strict priority.
  - On a handshake: load the shift register with the selected packet, set src, set index=0, go to SEND.
  - Latency: out_valid rises on the cycle after acceptance.
- SEND:
  - out_valid=1, out_data=shreg[127:96], out_last=(index==3), out_is_tt=src.
  - On out_valid&out_ready: shift left by 32 and increment index.
  - On the word-3 transfer, the block may accept a new packet in the same cycle: tt_ready/ev_ready follow the IDLE rules gated by out_ready. This gives back-to-back packets at 4 cycles per packet. With no new packet offered, go to IDLE.
- While out_ready=0: out_data, out_last and out_valid hold stable. No word is ever dropped or reordered once out_valid is high.
- tt_stall = 1 in SEND with src=event, except on the word-3 cycle when out_ready=1. This lets a waiting time tag be granted at the packet boundary.
  - tt_stall is combinational from state and out_ready. It never blocks a time-tag packet already in flight.
- Simultaneous tt_valid and ev_valid: the time tag wins. The event stays pending, is granted next, and is never lost.
- Reset mid-packet: the partial packet is discarded and out_valid drops immediately. The upstream data stays with its source, which re-presents it after reset.
- err_count saturates at all-ones and never wraps.

Optional Feature:
- Macro: FRAME_CHECK_EN.
- Defined:
  - Every accepted packet whose bits [127:123] are not 5'b11111 is consumed (ready asserted normally) but not serialized.
  - The state stays or returns to IDLE, and err_count increments by 1 (saturating).
- Undefined:
  - All packets are forwarded unchanged and err_count is constant 0.

Test Plan:
- Single tt 0xF8000000_00000000_00000000_00001234 with out_ready=1 → out_valid rises 1 cycle after the handshake. Words are 0xF8000000, 0x00000000, 0x00000000, 0x00001234. out_last on word 4 only, out_is_tt=1.
- tt_valid and ev_valid high in the same cycle → tt_ready=1, ev_ready=0. Tag words are sent first, then the event is granted on the tag's last-word cycle. 8 words in 8 consecutive cycles.
- Event in SEND with tt_valid pending → tt_stall=1 for words 0–2, 0 on the word-3 transfer cycle. The tag is accepted that cycle.
- out_ready toggled 1,0,0,1,... during a packet → out_data held during the stalls. Exactly 4 words, in order, and no handshake on the input side until word 3 transfers.
- rst pulsed during word 2 → out_valid=0 and tt_stall=0 asynchronously. After release, state=IDLE and the next packet is sent from word 0.
- FRAME_CHECK_EN, ev with bits [127:123]=5'b01111 → ev_ready=1, no out_valid, err_count 0→1. Forcing 65535 then one more bad packet leaves it at 65535.

Source files
------------

// File: rtl/tag_event_serializer.sv
// tag_event_serializer
// Arbitrates between the 128-bit time-tag stream and the 128-bit single-event
// stream and serializes each accepted packet as OUT_W-bit words, MSB word
// first, on a valid/ready uplink.
//
// Ports:
//   clk, rst            system clock; asynchronous active-high reset
//   tt_valid/tt_ready   time-tag input handshake, tt = 128-bit packet
//   tt_stall            to the generator's stall input (masks its valid)
//   ev_valid/ev_ready   single-event input handshake, ev = 128-bit packet
//   out_valid/out_ready uplink handshake
//   out_data            current word, out_last marks the final word
//   out_is_tt           current packet came from the time-tag source
//   err_count           saturating framing-error count
//
// Optional feature (macro FRAME_CHECK_EN): packets whose top 5 bits are not
// all ones are consumed but dropped, and err_count increments (saturating).
// With the macro undefined every packet is forwarded and err_count stays 0.
module tag_event_serializer #(
  parameter int unsigned OUT_W = 32,
  parameter int unsigned ERR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tt_valid,
  output logic              tt_ready,
  input  logic [127:0]      tt,
  output logic              tt_stall,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic [127:0]      ev,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              out_is_tt,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned PKT_W = 128;
  localparam int unsigned WORDS = PKT_W / OUT_W;
  localparam int unsigned IDX_W = $clog2(WORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PKT_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               src_q, src_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               sending;
  logic               last_word;
  logic               word_xfer;
  logic               last_xfer;
  logic               accept_win;
  logic               accept;
  logic               frame_ok;
  logic [PKT_W-1:0]   pkt_sel;

  assign sending   = (state_q == SEND);
  assign last_word = (idx_q == IDX_W'(WORDS - 1));
  assign word_xfer = sending & out_ready;
  assign last_xfer = word_xfer & last_word;

  // Accept in IDLE, or on the final word transfer for back-to-back packets.
  // Held off while reset is asserted so no handshake is seen during reset.
  assign accept_win = ~rst & (~sending | last_xfer);
  assign tt_ready   = accept_win & tt_valid;
  assign ev_ready   = accept_win & ev_valid & ~tt_valid;
  assign accept     = tt_ready | ev_ready;
  assign pkt_sel    = tt_valid ? tt : ev;

  // Hold the generator off during an event packet, but release it on the
  // final word transfer so a waiting tag can be granted at the boundary.
  assign tt_stall = sending & ~src_q & ~(last_word & out_ready);

  assign out_valid = sending;
  assign out_data  = shreg_q[PKT_W-1 -: OUT_W];
  assign out_last  = sending & last_word;
  assign out_is_tt = sending & src_q;
  assign err_count = err_q;

`ifdef FRAME_CHECK_EN
  localparam int unsigned HDR_W = 5;
  assign frame_ok = (pkt_sel[PKT_W-1 -: HDR_W] == {HDR_W{1'b1}});
`else
  assign frame_ok = 1'b1;
`endif

  // Next-state logic: word shift, then optional reload on acceptance.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    src_d   = src_q;
    err_d   = err_q;

    if (word_xfer) begin
      shreg_d = shreg_q << OUT_W;
      idx_d   = idx_q + IDX_W'(1);
      if (last_word) begin
        state_d = IDLE;
      end
    end

    if (accept) begin
      if (frame_ok) begin
        shreg_d = pkt_sel;
        src_d   = tt_ready;
        idx_d   = '0;
        state_d = SEND;
      end else if (err_q != {ERR_W{1'b1}}) begin
        err_d = err_q + ERR_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      src_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tag_event_serializer.sv
// Bench for tag_event_serializer: table-driven packets, scoreboard of
// expected output words, and hand-written multi-cycle corner cases.
module tb_tag_event_serializer;

  logic          clk = 1'b0;
  logic          rst;
  logic          tt_valid;
  logic          tt_ready;
  logic [127:0]  tt;
  logic          tt_stall;
  logic          ev_valid;
  logic          ev_ready;
  logic [127:0]  ev;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic          out_is_tt;
  logic [15:0]   err_count;

  tag_event_serializer #(.OUT_W(32), .ERR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .tt_valid  (tt_valid),
    .tt_ready  (tt_ready),
    .tt        (tt),
    .tt_stall  (tt_stall),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev        (ev),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_is_tt (out_is_tt),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_tt;
    logic [127:0] pkt;
    logic [31:0]  e0, e1, e2, e3;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        is_tt;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic push_vec(input int i);
    exp_t e;
    logic [31:0] w [4];
    w[0] = vecs[i].e0; w[1] = vecs[i].e1; w[2] = vecs[i].e2; w[3] = vecs[i].e3;
    for (int k = 0; k < 4; k++) begin
      e.data  = w[k];
      e.last  = (k == 3);
      e.is_tt = vecs[i].is_tt;
      sb.push_back(e);
    end
  endtask

  // Output monitor: every valid word must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_word");
      end else begin
        chk("word_data",  out_data,  sb[0].data);
        chk("word_last",  out_last,  sb[0].last);
        chk("word_is_tt", out_is_tt, sb[0].is_tt);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Offer one table packet from IDLE with out_ready=1 and check latency.
  task automatic send_vec(input int i);
    bit got;
    @(posedge clk); #1;
    if (vecs[i].is_tt) begin tt_valid = 1'b1; tt = vecs[i].pkt; end
    else               begin ev_valid = 1'b1; ev = vecs[i].pkt; end
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = vecs[i].is_tt ? tt_ready : ev_ready;
    end
    if (!got) begin
      fail_now("accept");
      tt_valid = 1'b0; ev_valid = 1'b0;
      return;
    end
    push_vec(i);
    chk("lat_accept_cycle", out_valid, 1'b0);
    @(posedge clk); #1;
    tt_valid = 1'b0; ev_valid = 1'b0;
    @(negedge clk);
    chk("lat_next_cycle", out_valid, 1'b1);
    drain();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    int  cyc;
    bit  done;
    bit  exp_rdy;

    vecs[0] = '{1'b1, 128'hF8000000_00000000_00000000_00001234,
                32'hF8000000, 32'h00000000, 32'h00000000, 32'h00001234};
    vecs[1] = '{1'b0, 128'hFFFFFFFF_12345678_9ABCDEF0_0F0F0F0F,
                32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
    vecs[2] = '{1'b1, 128'hFC00ABCD_DEADBEEF_00000001_80000000,
                32'hFC00ABCD, 32'hDEADBEEF, 32'h00000001, 32'h80000000};
    vecs[3] = '{1'b0, 128'hF8000001_FFFFFFFF_00000000_A5A5A5A5,
                32'hF8000001, 32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5};

    // Reset state, with sources offering so ready must stay low.
    rst = 1'b1; tt_valid = 1'b1; ev_valid = 1'b1; tt = '0; ev = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last",  out_last,  1'b0);
    chk("rst_out_is_tt", out_is_tt, 1'b0);
    chk("rst_out_data",  out_data,  32'h0);
    chk("rst_tt_ready",  tt_ready,  1'b0);
    chk("rst_ev_ready",  ev_ready,  1'b0);
    chk("rst_tt_stall",  tt_stall,  1'b0);
    chk("rst_err_count", err_count, 16'h0);
    tt_valid = 1'b0; ev_valid = 1'b0;
    rst = 1'b0;

    // Table-driven single packets.
    for (int i = 0; i < 4; i++) send_vec(i);

    // Simultaneous offer: tag first, event granted on tag's last word.
    @(posedge clk); #1;
    tt_valid = 1'b1; tt = vecs[0].pkt;
    ev_valid = 1'b1; ev = vecs[1].pkt;
    @(negedge clk);
    chk("prio_tt_ready", tt_ready, 1'b1);
    chk("prio_ev_ready", ev_ready, 1'b0);
    push_vec(0);
    @(posedge clk); #1;
    tt_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("b2b_out_valid", out_valid, 1'b1);
      if (c < 4) chk("b2b_ev_wait", ev_ready, 1'b0);
      if (c == 4) begin
        chk("b2b_ev_grant", ev_ready, 1'b1);
        push_vec(1);
      end
      @(posedge clk); #1;
      if (c == 4) ev_valid = 1'b0;
    end
    drain();

    // Event in flight with a tag pending: stall until the last word.
    @(posedge clk); #1;
    ev_valid = 1'b1; ev = vecs[3].pkt;
    @(negedge clk);
    chk("stall_ev_ready", ev_ready, 1'b1);
    chk("stall_idle", tt_stall, 1'b0);
    push_vec(3);
    @(posedge clk); #1;
    ev_valid = 1'b0; tt_valid = 1'b1; tt = vecs[2].pkt;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        chk("stall_high", tt_stall, 1'b1);
        chk("stall_tt_wait", tt_ready, 1'b0);
      end else begin
        chk("stall_release", tt_stall, 1'b0);
        chk("stall_tt_grant", tt_ready, 1'b1);
        push_vec(2);
      end
      @(posedge clk); #1;
      if (c == 4) tt_valid = 1'b0;
    end
    drain();

    // Backpressure 1,0,0,... with an event waiting for the packet boundary.
    @(posedge clk); #1;
    tt_valid = 1'b1; tt = vecs[2].pkt;
    @(negedge clk);
    chk("bp_tt_ready", tt_ready, 1'b1);
    push_vec(2);
    @(posedge clk); #1;
    tt_valid = 1'b0; ev_valid = 1'b1; ev = vecs[1].pkt;
    sent = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      out_ready = (cyc % 3 == 0);
      @(negedge clk);
      exp_rdy = (sent == 3) && out_ready;
      chk("bp_ev_ready", ev_ready, exp_rdy);
      if (ev_ready) push_vec(1);
      done = exp_rdy | ev_ready;
      if (out_ready) sent++;
      @(posedge clk); #1;
      cyc++;
      if (done) ev_valid = 1'b0;
    end
    if (!done) fail_now("bp_boundary");
    ev_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset during word 2 of an event packet.
    @(posedge clk); #1;
    ev_valid = 1'b1; ev = vecs[1].pkt;
    @(negedge clk);
    chk("rst_mid_accept", ev_ready, 1'b1);
    push_vec(1);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_pre_stall", tt_stall, 1'b1);
    #1;
    rst = 1'b1; tt_valid = 1'b1; tt = vecs[0].pkt;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_tt_stall",  tt_stall,  1'b0);
    chk("rst_mid_tt_ready",  tt_ready,  1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; tt_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", out_valid, 1'b0);
    send_vec(0);

`ifdef FRAME_CHECK_EN
    // Bad header: consumed, not serialized, counted, saturating.
    @(posedge clk); #1;
    ev_valid = 1'b1; ev = 128'h78000000_00000000_00000000_00000001;
    @(negedge clk);
    chk("fc_ev_ready", ev_ready, 1'b1);
    chk("fc_err_before", err_count, 16'd0);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("fc_no_output", out_valid, 1'b0);
    end
    chk("fc_err_one", err_count, 16'd1);
    @(posedge clk); #1;
    ev_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    ev_valid = 1'b0;
    @(negedge clk);
    chk("fc_err_saturate", err_count, 16'hFFFF);
`else
    chk("err_count_constant", err_count, 16'd0);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
